// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, edge-triggered start detect,
// mid-bit sampling, valid/ready output register with overrun and framing-error pulses.
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | timing to mid start bit; re-checks the line to reject glitches
// DATA  | sampling 8 data bits LSB first, one per bit period
// STOP  | timing to mid stop bit; delivers the byte or flags a framing error
module uart_rx #(
  parameter int CLK_FREQ = 100,
  parameter int BIT_RATE = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_i,
  input  logic       ready,
  output logic       valid,
  output logic [7:0] data,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CYCLE = (CLK_FREQ * 1000 * 1000) / BIT_RATE;
  localparam int HALF  = CYCLE / 2;
  localparam int CW    = $clog2(CYCLE);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLE - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_d;
  logic          rx_m, rx_s, rx_p;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    bits;
  logic          sample, deliver, stop_bad;

  assign busy = (state != IDLE);

  always_comb begin
    state_d  = state;
    sample   = 1'b0;
    deliver  = 1'b0;
    stop_bad = 1'b0;
    case (state)
      IDLE:  if (rx_p && !rx_s) state_d = START;
      START: if (cnt == CNT_HALF) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (cnt == CNT_LAST) begin
          sample = 1'b1;
          if (bit_cnt == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt == CNT_LAST) begin
          state_d  = IDLE;
          deliver  = rx_s;
          stop_bad = !rx_s;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      rx_p      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      bits      <= '0;
      valid     <= 1'b0;
      data      <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_m  <= uart_i;
      rx_s  <= rx_m;
      rx_p  <= rx_s;
      state <= state_d;

      if (state_d != state) begin
        cnt     <= '0;
        bit_cnt <= '0;
      end else if (state != IDLE) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        if (sample) bit_cnt <= bit_cnt + 3'd1;
      end

      if (sample) bits[bit_cnt] <= rx_s;

      frame_err <= stop_bad;
      overrun   <= deliver && valid && !ready;

      // a consume in the same cycle frees the register for the new byte
      if (deliver && (!valid || ready)) begin
        data  <= bits;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
